// File: rtl/zigzag_rle_encoder_if.sv
// Stream bundle between a block producer and the zigzag RLE encoder:
// a 64-coefficient block goes in, (run, size, amp) symbols come out.
interface zigzag_rle_encoder_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64
);
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] in_block;
  logic                              dc_clear;
  logic                              out_valid;
  logic                              out_ready;
  logic [3:0]                        out_run;
  logic [3:0]                        out_size;
  logic [10:0]                       out_amp;
  logic                              out_is_dc;
  logic                              out_last;

  modport master (
    output in_valid, in_block, dc_clear, out_ready,
    input  in_ready, out_valid, out_run, out_size, out_amp, out_is_dc, out_last
  );

  modport slave (
    input  in_valid, in_block, dc_clear, out_ready,
    output in_ready, out_valid, out_run, out_size, out_amp, out_is_dc, out_last
  );
endinterface

// File: rtl/zigzag_rle_encoder.sv
// Zigzag-ordered block to JPEG-style symbol stream: DC difference against a
// running predictor, then run-length coded AC coefficients with ZRL and EOB.
module zigzag_rle_encoder #(
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_COUNT = 64
) (
  input  logic                clk,
  input  logic                reset,
  zigzag_rle_encoder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, AC, EOB} state_t;

  localparam logic signed [DATA_WIDTH-1:0] COEF_MAX = DATA_WIDTH'(1023);
  localparam logic signed [DATA_WIDTH-1:0] COEF_MIN = DATA_WIDTH'(-1023);

  function automatic logic signed [10:0] clamp_coef(input logic signed [DATA_WIDTH-1:0] v);
    if (v > COEF_MAX)      return 11'sd1023;
    else if (v < COEF_MIN) return -11'sd1023;
    else                   return v[10:0];
  endfunction

  // Magnitude category: bit length of |v|, zero for v = 0.
  function automatic logic [3:0] size_of(input logic signed [11:0] v);
    logic [11:0] mag;
    logic [3:0]  s;
    mag = v[11] ? 12'(-v) : 12'(v);
    s   = '0;
    for (int i = 0; i < 11; i++) begin
      if (mag[i]) s = 4'(i + 1);
    end
    return s;
  endfunction

  function automatic logic [10:0] amp_of(input logic signed [11:0] v, input logic [3:0] size);
    logic [11:0] adj;
    logic [11:0] mask;
    adj  = v[11] ? 12'(v - 12'sd1) : 12'(v);
    mask = (12'd1 << size) - 12'd1;
    return 11'(adj & mask);
  endfunction

  state_t             state;
  state_t             state_next;
  logic signed [10:0] coef [PIXEL_COUNT];
  logic signed [10:0] pred;
  logic [5:0]         k;
  logic [5:0]         run;
  logic [5:0]         last_nz;
  logic [5:0]         in_last_nz;
  logic signed [11:0] dc_diff;
  logic signed [11:0] ac_val;
  logic [3:0]         dc_size;
  logic [3:0]         ac_size;
  logic               ac_zero;

  always_comb begin
    in_last_nz = '0;
    for (int i = 1; i < PIXEL_COUNT; i++) begin
      if (bus.in_block[i*DATA_WIDTH +: DATA_WIDTH] != '0) in_last_nz = 6'(i);
    end
  end

  assign dc_diff = {coef[0][10], coef[0]} - {pred[10], pred};
  assign ac_val  = {coef[k][10], coef[k]};
  assign dc_size = size_of(dc_diff);
  assign ac_size = size_of(ac_val);
  assign ac_zero = (ac_val == '0);

  // The whole block is latched at acceptance so the producer is free immediately.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.in_valid) begin
      for (int i = 0; i < PIXEL_COUNT; i++) begin
        coef[i] <= clamp_coef(bus.in_block[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // dc_clear zeroes the predictor at acceptance, so the DC symbol sees c0 - 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pred    <= '0;
      run     <= '0;
      k       <= '0;
      last_nz <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            last_nz <= in_last_nz;
            k       <= 6'd1;
            run     <= '0;
            if (bus.dc_clear) pred <= '0;
          end
        end
        DC: begin
          if (bus.out_ready) pred <= coef[0];
        end
        SCAN: begin
          if (ac_zero && k < last_nz) begin
            run <= run + 6'd1;
            k   <= k + 6'd1;
          end
        end
        ZRL: begin
          if (bus.out_ready) run <= run - 6'd16;
        end
        AC: begin
          if (bus.out_ready) begin
            run <= '0;
            k   <= k + 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs depend only on registered state, so they hold steady under back-pressure.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_run   = '0;
    bus.out_size  = '0;
    bus.out_amp   = '0;
    bus.out_is_dc = 1'b0;
    bus.out_last  = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = DC;
      end
      DC: begin
        bus.out_valid = 1'b1;
        bus.out_is_dc = 1'b1;
        bus.out_size  = dc_size;
        bus.out_amp   = amp_of(dc_diff, dc_size);
        bus.out_last  = (last_nz == '0);
        if (bus.out_ready) state_next = (last_nz != '0) ? SCAN : IDLE;
      end
      SCAN: begin
        if (!ac_zero) state_next = (run >= 6'd16) ? ZRL : AC;
      end
      ZRL: begin
        bus.out_valid = 1'b1;
        bus.out_run   = 4'd15;
        if (bus.out_ready && run < 6'd32) state_next = AC;
      end
      AC: begin
        bus.out_valid = 1'b1;
        bus.out_run   = run[3:0];
        bus.out_size  = ac_size;
        bus.out_amp   = amp_of(ac_val, ac_size);
        bus.out_last  = (k == 6'd63);
        if (bus.out_ready) begin
          if (k == 6'd63)         state_next = IDLE;
          else if (k == last_nz)  state_next = EOB;
          else                    state_next = SCAN;
        end
      end
      EOB: begin
        bus.out_valid = 1'b1;
        bus.out_last  = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// Randomized scoreboard bench for zigzag_rle_encoder: a block-level reference
// model queues expected symbols, a monitor pops them as the DUT emits.
module tb_zigzag_rle_encoder;
  localparam int DW = 32;
  localparam int PC = 64;

  typedef struct packed {
    logic [3:0]  run;
    logic [3:0]  size;
    logic [10:0] amp;
    logic        is_dc;
    logic        last;
  } sym_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zigzag_rle_encoder_if #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC)) bus ();
  zigzag_rle_encoder #(.DATA_WIDTH(DW), .PIXEL_COUNT(PC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  sym_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   blk[64];
  int   model_pred = 0;
  int   ready_mode = 0;
  bit   stall_req = 1'b0;

  function automatic int clamp_ref(int v);
    if (v > 1023) return 1023;
    if (v < -1023) return -1023;
    return v;
  endfunction

  function automatic int size_ref(int v);
    int m;
    int s;
    m = (v < 0) ? -v : v;
    s = 0;
    while (m > 0) begin
      m = m / 2;
      s++;
    end
    return s;
  endfunction

  function automatic sym_t make_sym(int run, int v, bit is_dc, bit last);
    sym_t s;
    int   sz;
    sz = size_ref(v);
    s.run   = 4'(run);
    s.size  = 4'(sz);
    s.amp   = 11'((v >= 0) ? v : v + (1 << sz) - 1);
    s.is_dc = is_dc;
    s.last  = last;
    return s;
  endfunction

  // Encodes the whole block from first principles and appends its symbols.
  function automatic void predict_block(bit clr);
    int c[64];
    int last_nz;
    int run;
    last_nz = 0;
    run     = 0;
    for (int i = 0; i < 64; i++) c[i] = clamp_ref(blk[i]);
    for (int i = 1; i < 64; i++) if (c[i] != 0) last_nz = i;
    exp_q.push_back(make_sym(0, c[0] - (clr ? 0 : model_pred), 1'b1, last_nz == 0));
    model_pred = c[0];
    for (int i = 1; i < 64; i++) begin
      if (c[i] == 0) begin
        run++;
      end else begin
        while (run >= 16) begin
          exp_q.push_back(make_sym(15, 0, 1'b0, 1'b0));
          run -= 16;
        end
        exp_q.push_back(make_sym(run, c[i], 1'b0, i == 63));
        run = 0;
      end
    end
    if (last_nz > 0 && last_nz < 63) exp_q.push_back(make_sym(0, 0, 1'b0, 1'b1));
  endfunction

  task automatic check_output(string name, sym_t exp);
    sym_t got;
    got = {bus.out_run, bus.out_size, bus.out_amp, bus.out_is_dc, bus.out_last};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got run=%0d size=%0d amp=%0d dc=%0b last=%0b, expected run=%0d size=%0d amp=%0d dc=%0b last=%0b",
               name, got.run, got.size, got.amp, got.is_dc, got.last,
               exp.run, exp.size, exp.amp, exp.is_dc, exp.last);
    end
  endtask

  task automatic check_bit(string name, logic actual, logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic clear_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  task automatic apply_stimulus(bit clr);
    int n;
    n = 0;
    predict_block(clr);
    @(negedge clk);
    for (int i = 0; i < 64; i++) bus.in_block[i*DW +: DW] = blk[i];
    bus.dc_clear = clr;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stayed %b after %0d cycles, expected 1", bus.in_ready, n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.dc_clear = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.in_ready) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || !bus.in_ready) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d symbols still pending, in_ready=%b, expected 0 pending", exp_q.size(), bus.in_ready);
      exp_q.delete();
    end
  endtask

  // Monitor: drives out_ready, optionally stalls the first AC, pops on handshake.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_req && bus.out_valid && !bus.out_is_dc) begin
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
          #1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL stall_hold: symbol presented with no expectation queued");
          end else begin
            check_output("stall_hold", exp_q[0]);
          end
          check_bit("stall_valid", bus.out_valid, 1'b1);
          check_bit("stall_in_ready", bus.in_ready, 1'b0);
          @(negedge clk);
        end
        stall_req = 1'b0;
      end
      bus.out_ready = (ready_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_symbol: run=%0d size=%0d amp=%0d last=%0b with empty queue",
                   bus.out_run, bus.out_size, bus.out_amp, bus.out_last);
        end else begin
          check_output("symbol", exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    int dens;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.dc_clear = 1'b0;
    bus.in_block = '0;
    repeat (3) @(negedge clk);
    #2;
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check_bit("rst_out_last", bus.out_last, 1'b0);
    check_bit("rst_out_is_dc", bus.out_is_dc, 1'b0);
    checks++;
    if ({bus.out_run, bus.out_size, bus.out_amp} !== 19'd0) begin
      errors++;
      $display("[TB] FAIL rst_fields: got %h, expected 0", {bus.out_run, bus.out_size, bus.out_amp});
    end
    reset = 1'b0;
    @(negedge clk);
    #2;
    check_bit("post_rst_in_ready", bus.in_ready, 1'b1);

    $display("[TB] directed DC predictor blocks");
    ready_mode = 1;
    clear_blk(); blk[0] = 50; apply_stimulus(1'b0); wait_drain();
    clear_blk(); blk[0] = 40; apply_stimulus(1'b0); wait_drain();

    $display("[TB] directed AC, ZRL and clamp blocks");
    clear_blk(); blk[1] = -3; blk[5] = 1; apply_stimulus(1'b1); wait_drain();
    clear_blk(); blk[40] = 7; apply_stimulus(1'b1); wait_drain();
    clear_blk(); blk[63] = 2000; apply_stimulus(1'b1); wait_drain();

    $display("[TB] back-pressure on first AC, then dc_clear");
    stall_req = 1'b1;
    clear_blk(); blk[0] = 12; blk[1] = -3; blk[5] = 1; apply_stimulus(1'b0); wait_drain();
    check_bit("stall_exercised", stall_req, 1'b0);
    clear_blk(); blk[0] = -300; blk[2] = 9; apply_stimulus(1'b1); wait_drain();

    $display("[TB] reset during SCAN");
    clear_blk(); blk[0] = 5; blk[60] = 3; apply_stimulus(1'b0);
    repeat (5) @(negedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_bit("mid_rst_out_valid", bus.out_valid, 1'b0);
    exp_q.delete();
    model_pred = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #2;
      check_bit("after_rst_out_valid", bus.out_valid, 1'b0);
      check_bit("after_rst_in_ready", bus.in_ready, 1'b1);
    end
    clear_blk(); blk[0] = 77; blk[3] = -1; apply_stimulus(1'b0); wait_drain();

    $display("[TB] randomized blocks with random back-pressure");
    ready_mode = 0;
    for (int b = 0; b < 40; b++) begin
      dens = int'($urandom_range(2, 45));
      for (int i = 0; i < 64; i++) begin
        r = int'($urandom_range(0, 99));
        if (i == 0)          blk[i] = int'($urandom_range(0, 3000)) - 1500;
        else if (r >= dens)  blk[i] = 0;
        else if (r < 3)      blk[i] = int'($urandom_range(900, 6000)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
        else                 blk[i] = int'($urandom_range(1, 80)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      end
      if ($urandom_range(0, 5) == 0) blk[63] = int'($urandom_range(1, 1500)) - 750;
      apply_stimulus($urandom_range(0, 7) == 0);
    end
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zigzag_rle_encoder.md
ZIGZAG_RLE_ENCODER -- requirements
Module: zigzag_rle_encoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of one zigzag coefficient (signed two's-complement integer).
REQ-002 SHALL have parameter PIXEL_COUNT, default 64, meaning the number of coefficients per block (fixed 64; other values unsupported).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: in_block holds a valid zigzag-ordered block.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a new block this cycle.
REQ-007 SHALL have port in_block, input, DATA_WIDTH*PIXEL_COUNT bits: coefficient k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]; k=0 is DC.
REQ-008 SHALL have port dc_clear, input, 1 bit: sampled only on an input handshake; the accepted block uses DC predictor 0.
REQ-009 SHALL have port out_valid, output, 1 bit: a symbol is presented.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the symbol.
REQ-011 SHALL have port out_run, output, 4 bits: zero-run preceding the coefficient.
REQ-012 SHALL have port out_size, output, 4 bits: magnitude category, 0..11.
REQ-013 SHALL have port out_amp, output, 11 bits: amplitude bits, LSB-aligned, upper bits zero.
REQ-014 SHALL have port out_is_dc, output, 1 bit: the symbol is the DC difference.
REQ-015 SHALL have port out_last, output, 1 bit: the symbol is the final symbol of the block.

Function
REQ-016 SHALL have FSM states IDLE, DC, SCAN, ZRL, AC, EOB; in_ready=1 only in IDLE.
REQ-017 SHALL, on in_valid&&in_ready, register all 64 coefficients, clamp each to [-1023,+1023], compute last_nz (highest k in 1..63 with a nonzero clamped value, else 0), and go to DC.
REQ-018 SHALL present in DC: diff = c0 - pred (12-bit signed), run=0, is_dc=1, last=1 only if last_nz=0; the input-to-DC-symbol latency SHALL be 1 cycle.
REQ-019 SHALL load pred <= c0 on the DC symbol handshake (predictor 0 if dc_clear was captured); next state SCAN if last_nz>0, else IDLE.
REQ-020 SHALL examine one coefficient per cycle in SCAN, k from 1: a zero with k<last_nz increments run and k; a nonzero goes to ZRL if run>=16, else AC.
REQ-021 SHALL present in ZRL: run=15, size=0, amp=0; on handshake run -= 16; stay in ZRL while run>=16, else go to AC.
REQ-022 SHALL present in AC: run, size and amp of c_k; on handshake run=0, k+=1; go to IDLE if k=63, to EOB if k=last_nz<63, else to SCAN.
REQ-023 SHALL present in EOB: run=0, size=0, amp=0, last=1; on handshake go to IDLE.
REQ-024 SHALL set out_last on the AC symbol of k=63 when c63 is nonzero, and SHALL then emit no EOB.
REQ-025 SHALL compute size as the bit length of |v| (0 for v=0); amp SHALL be v for v>0 and the low size bits of (v-1) for v<0.
REQ-026 SHALL emit ZRL only before a following nonzero; trailing zeros SHALL produce only EOB.
REQ-027 SHALL hold out_valid and every out_* field stable while out_valid&&!out_ready; out_valid SHALL be 1 in states DC, ZRL, AC and EOB.
REQ-028 SHALL drive in_ready=1 in IDLE only; back-to-back blocks therefore have at least one IDLE cycle between them.

Reset
REQ-029 SHALL, while reset=1, force state IDLE, out_valid=0, in_ready=1 after release, pred=0, run=0, k=0, and all out_* fields to 0.
REQ-030 SHALL, on reset assertion mid-block, discard the block; no partial symbols SHALL follow release.

Verification
REQ-031 SHALL cover this scenario: first block after reset with c0=50 and all AC=0 -> DC (size 6, amp 50), last=1; then c0=40 -> DC diff -10 (size 4, amp 5).
REQ-032 SHALL cover this scenario: c0=0, c1=-3, c5=1, rest 0 -> DC(0,0); AC(run0, size2, amp0); AC(run3, size1, amp1); EOB with last=1.
REQ-033 SHALL cover this scenario: c0=0, only c40=7 -> DC; ZRL, ZRL; AC(run7, size3, amp7); EOB.
REQ-034 SHALL cover this scenario: only c63=2000 -> clamped 1023; 3 ZRL; AC(run14, size10, amp1023, last=1); no EOB.
REQ-035 SHALL cover this scenario: out_ready held low 5 cycles on the first AC -> fields stable, in_ready=0; dc_clear with the next block -> its DC diff = c0.
REQ-036 SHALL cover this scenario: reset pulsed during SCAN -> out_valid=0 immediately; the next block's DC uses pred 0.
